fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding read at a time, branch redirects,
// downstream stall handling and a count of instructions consumed.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        VALID = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] instr_pc_r;
    logic [31:0] fetch_count_r;
    logic        imem_req_r;
    logic        instr_valid_r;
    logic        fetch_err_r;

    logic [31:0] redirect_target_s;
    logic        redirect_misaligned_s;

    // Misaligned targets are forced down to the containing word.
    assign redirect_target_s     = {redirect_pc[31:2], 2'b00};
    assign redirect_misaligned_s = (redirect_pc[1:0] != 2'b00);

    // Fetch FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            instr_r       <= 32'h0000_0000;
            instr_pc_r    <= 32'h0000_0000;
            fetch_err_r   <= 1'b0;
            fetch_count_r <= 32'h0000_0000;
        end else begin
            fetch_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r    <= REQ;
                    imem_req_r <= 1'b1;
                end
                REQ: begin
                    if (redirect) begin
                        pc_r        <= redirect_target_s;
                        fetch_err_r <= redirect_misaligned_s;
                    end
                    // An accepted request that is redirected still owes us a response.
                    if (imem_ready) begin
                        imem_req_r <= 1'b0;
                        state_r    <= redirect ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid && !redirect) begin
                        instr_r       <= imem_rdata;
                        instr_pc_r    <= pc_r;
                        pc_r          <= pc_r + 32'd4;
                        instr_valid_r <= 1'b1;
                        state_r       <= VALID;
                    end else if (imem_rvalid) begin
                        pc_r        <= redirect_target_s;
                        fetch_err_r <= redirect_misaligned_s;
                        imem_req_r  <= 1'b1;
                        state_r     <= REQ;
                    end else if (redirect) begin
                        pc_r        <= redirect_target_s;
                        fetch_err_r <= redirect_misaligned_s;
                        state_r     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc_r        <= redirect_target_s;
                        fetch_err_r <= redirect_misaligned_s;
                    end
                    if (imem_rvalid) begin
                        imem_req_r <= 1'b1;
                        state_r    <= REQ;
                    end
                end
                VALID: begin
                    if (redirect) begin
                        pc_r          <= redirect_target_s;
                        fetch_err_r   <= redirect_misaligned_s;
                        instr_valid_r <= 1'b0;
                        imem_req_r    <= 1'b1;
                        state_r       <= REQ;
                    end else if (!stall) begin
                        fetch_count_r <= fetch_count_r + 32'd1;
                        instr_valid_r <= 1'b0;
                        imem_req_r    <= 1'b1;
                        state_r       <= REQ;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    imem_req_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = instr_valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign opcode      = instr_r[6:0];
    assign fetch_err   = fetch_err_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random
// traffic against a flag-based behavioural model and a randomly-delayed memory.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        fetch_err;
    logic [31:0] fetch_count;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .fetch_err(fetch_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: "waiting for a response", "holding an instruction", "response is stale".
    bit          m_idle, m_have, m_out, m_disc, m_err;
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt;

    bit mem_pend = 1'b0;
    int mem_dly  = 0;
    int mem_lat  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_have = 1'b0; m_out = 1'b0; m_disc = 1'b0; m_err = 1'b0;
        m_pc = RST_PC; m_instr = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit          mis;
        bit          err_n;
        tgt   = {redirect_pc[31:2], 2'b00};
        mis   = (redirect_pc[1:0] != 2'b00);
        err_n = 1'b0;
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_have) begin
            if (redirect) begin
                m_have = 1'b0; m_pc = tgt; err_n = mis;
            end else if (!stall) begin
                m_have = 1'b0; m_cnt = m_cnt + 32'd1;
            end
        end else if (!m_out) begin
            if (imem_ready) begin
                m_out = 1'b1; m_disc = redirect;
            end
            if (redirect) begin
                m_pc = tgt; err_n = mis;
            end
        end else begin
            if (imem_rvalid) begin
                m_out = 1'b0;
                if (!m_disc && !redirect) begin
                    m_have = 1'b1; m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
                end
            end else if (redirect) begin
                m_disc = 1'b1;
            end
            if (redirect) begin
                m_pc = tgt; err_n = mis;
            end
        end
        m_err = err_n;
    endtask

    task automatic compare();
        chk1("imem_req", imem_req, !m_idle && !m_have && !m_out);
        chk("imem_addr", imem_addr, m_pc);
        chk1("instr_valid", instr_valid, m_have);
        chk1("fetch_err", fetch_err, m_err);
        chk("fetch_count", fetch_count, m_cnt);
        if (m_have) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", instr_pc, m_ipc);
            chk("opcode", {25'd0, opcode}, {25'd0, m_instr[6:0]});
        end
    endtask

    // One clock: memory drives its response, edge, model and memory advance, then compare.
    task automatic tick();
        bit acc;
        bit delivered;
        delivered   = mem_pend && (mem_dly == 0);
        imem_rvalid = delivered;
        imem_rdata  = $urandom;
        acc         = imem_req && imem_ready;
        @(posedge clk);
        model_step();
        if (delivered) mem_pend = 1'b0;
        else if (mem_pend) mem_dly--;
        if (acc) begin
            mem_pend = 1'b1;
            mem_dly  = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_rvalid = 1'b0; redirect = 1'b0; stall = 1'b0; imem_ready = 1'b0;
        mem_pend = 1'b0;
        model_reset();
        #1;
        chk1("rst_imem_req", imem_req, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk1("rst_fetch_err", fetch_err, 1'b0);
        chk("rst_fetch_count", fetch_count, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0000_0080);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        compare();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!instr_valid && n < budget) begin
            tick();
            n++;
        end
        chk1({name, "_timeout"}, instr_valid, 1'b1);
    endtask

    initial begin
        logic [31:0] seq_exp [3];
        seq_exp = '{32'h0000_0080, 32'h0000_0084, 32'h0000_0088};
        @(negedge clk);
        do_reset();

        // First edge after release leaves IDLE and presents RESET_PC.
        tick();
        chk1("start_req", imem_req, 1'b1);
        chk("start_addr", imem_addr, 32'h0000_0080);

        // Sequential fetch at minimum latency.
        mem_lat = 0; imem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid("seq", 20);
            chk("seq_pc", instr_pc, seq_exp[k]);
            tick();
        end
        chk("seq_count", fetch_count, 32'd3);

        // Stall hold for five cycles, then release.
        wait_valid("stall", 20);
        chk("stall_pc0", instr_pc, 32'h0000_008C);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_pc", instr_pc, 32'h0000_008C);
            chk("stall_count", fetch_count, 32'd3);
            chk1("stall_valid", instr_valid, 1'b1);
        end
        stall = 1'b0;
        tick();
        chk("stall_rel_count", fetch_count, 32'd4);
        chk("stall_rel_addr", imem_addr, 32'h0000_0090);

        // Redirect while the response is still outstanding.
        mem_lat = 3;
        tick();
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        chk("wait_redir_addr", imem_addr, 32'h0000_0100);
        redirect = 1'b0; imem_ready = 1'b1; mem_lat = 0;
        wait_valid("wait_redir", 30);
        chk("wait_redir_pc", instr_pc, 32'h0000_0100);

        // Redirect beats consume in VALID.
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        chk("valid_redir_count", fetch_count, 32'd4);
        chk("valid_redir_addr", imem_addr, 32'h0000_0200);
        chk1("valid_redir_req", imem_req, 1'b1);

        // Misaligned redirect.
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        chk1("mis_err", fetch_err, 1'b1);
        chk("mis_addr", imem_addr, 32'h0000_0100);
        redirect = 1'b0;
        tick();
        chk1("mis_err_clear", fetch_err, 1'b0);

        // Reset in the middle of a WAIT.
        imem_ready = 1'b1; mem_lat = 5;
        tick();
        imem_ready = 1'b0;
        tick();
        chk1("wait_no_req", imem_req, 1'b0);
        do_reset();
        tick();
        chk("post_rst_addr", imem_addr, 32'h0000_0080);
        chk1("post_rst_req", imem_req, 1'b1);

        // Random traffic.
        mem_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                imem_ready  = ($urandom_range(0, 9) < 6);
                redirect    = ($urandom_range(0, 9) == 0);
                redirect_pc = $urandom & 32'h0000_0FFF;
                stall       = ($urandom_range(0, 9) < 3);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
